seven_seg_scan_mux: RTL and testbench
=====================================

// Module: seven_seg_scan_mux
// PURPOSE
//  Parametrised time-multiplexed seven-segment scanner; successor to the fixed 4-of-6 digit rotator.
//  Scans N_AN active-low anodes over a selectable window of N_DIG BCD digits.
//  Window changes use a req/ack handshake and are applied only at frame boundaries.
//  A programmable guard interval at the start of each digit slot blanks all anodes (anti-ghosting).
//  Sits between the timer/score digit sources and the board segment decoder.
// PARAMETERS
//  N_AN        4   number of physical anodes scanned
//  N_DIG       6   number of input digits (N_DIG >= N_AN)
//  PRESCALE_W  11  digit dwell = 2**PRESCALE_W clk cycles
//  GUARD       8   cycles at start of each dwell with all anodes off (GUARD < 2**PRESCALE_W)
//  OFS_W       $clog2(N_DIG-N_AN+1), min 1; width of window offset
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          asynchronous active-low reset
//  digits_in   in   4*N_DIG    packed BCD digits, digit k = [4k+3:4k], k=0 least significant
//  dp_in       in   N_DIG      decimal point request per digit, 1 = lit
//  win_sel     in   OFS_W      requested window offset (lowest displayed digit index)
//  win_req     in   1          window change request, sampled every cycle
//  win_ack     out  1          one-cycle pulse: pending offset applied
//  an          out  N_AN       anode enables, active low
//  digit_out   out  4          BCD digit for segment decoder
//  dp_n        out  1          decimal point, active low
//  frame_tick  out  1          one-cycle pulse at each frame start
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): prescaler p=0, scan index s=0, offset=0, no pending;
//    an=all 1, digit_out=0, dp_n=1, win_ack=0, frame_tick=0.
//  - p increments every cycle, wraps 2**PRESCALE_W-1 -> 0; on wrap s increments, N_AN-1 -> 0.
//  - Frame boundary = cycle with p==max and s==N_AN-1.
//  - All outputs registered; outputs in cycle t+1 reflect p, s, offset and inputs of cycle t.
//  - Displayed digit index d = offset + s; digit_out = digits_in[4d+3:4d]; dp_n = ~dp_in[d].
//  - an[s]=0 iff p >= GUARD; all other an bits 1; during guard an=all 1, digit_out/dp_n still driven.
//  - win_req=1 captures min(win_sel, N_DIG-N_AN) into pending and sets pending_valid.
//  - Further win_req while pending: overwrite pending (latest wins); only one ack per applied update.
//  - At frame boundary with pending_valid: offset <= pending, pending_valid cleared; win_ack=1 and
//    frame_tick=1 in the same cycle s returns to 0.
//  - win_req in the frame-boundary cycle itself is captured and applied at the NEXT boundary.
//  - No pending at boundary: offset unchanged, win_ack stays 0, frame_tick still pulses.
//  - digits_in/dp_in are not latched; changes appear on next registered update.
//  - Reset mid-frame: pending request discarded, no ack issued.
// CONFIGURATION
//  SEVENSEG_LZB_EN defined: leading-zero blanking within the window. Slot s is forced dark
//    (an[s]=1 whole dwell) when its digit and every higher digit in the window are 0, except
//    s=0, which is never blanked. dp_in on a blanked digit is also suppressed.
//  SEVENSEG_LZB_EN undefined: every slot lights after guard regardless of value.
// TESTING (PRESCALE_W=2, GUARD=1, N_AN=4, N_DIG=6 unless noted)
//  - Reset released -> an=4'b1111 for first cycle; then an sequence per slot 1111,1110x3, 1111,1101x3,
//    1111,1011x3, 1111,0111x3; frame_tick every 16 cycles.
//  - digits_in=24'h654321, offset 0 -> digit_out 1,2,3,4 in slots 0..3; win_req 1 cycle with
//    win_sel=2 mid-frame -> win_ack with next frame_tick, then digit_out 3,4,5,6.
//  - win_sel=3 (over-range) -> clamped offset 2; two reqs (1 then 0) in one frame -> single ack,
//    offset 0.
//  - win_req asserted exactly on frame-boundary cycle -> no ack that frame; ack at following boundary.
//  - rst_n low mid-dwell with request pending -> outputs to reset values immediately; no win_ack after release.
//  - SEVENSEG_LZB_EN, digits_in=24'h000050, offset 0 -> slots 2,3 an stay 1; slot 1 shows 5,
//    slot 0 shows 0; digits_in=0 -> only slot 0 lit.

Source files
------------

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed seven-segment scanner: N_AN active-low anodes over a movable window of N_DIG BCD digits.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module seven_seg_scan_mux #(
  parameter int N_AN       = 4,
  parameter int N_DIG      = 6,
  parameter int PRESCALE_W = 11,
  parameter int GUARD      = 8,
  parameter int OFS_W      = (N_DIG - N_AN + 1 > 1) ? $clog2(N_DIG - N_AN + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*N_DIG-1:0]   digits_in,
  input  logic [N_DIG-1:0]     dp_in,
  input  logic [OFS_W-1:0]     win_sel,
  input  logic                 win_req,
  output logic                 win_ack,
  output logic [N_AN-1:0]      an,
  output logic [3:0]           digit_out,
  output logic                 dp_n,
  output logic                 frame_tick
);
  localparam int S_W   = (N_AN > 1) ? $clog2(N_AN) : 1;
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [OFS_W-1:0]      MAX_OFS = OFS_W'(N_DIG - N_AN);
  localparam logic [S_W-1:0]        S_LAST  = S_W'(N_AN - 1);
  localparam logic [PRESCALE_W-1:0] GUARD_P = PRESCALE_W'(GUARD);

  logic [PRESCALE_W-1:0] p_reg;
  logic [S_W-1:0]        s_reg;
  logic [OFS_W-1:0]      offset_reg;
  logic [OFS_W-1:0]      pending_reg;
  logic                  pending_valid_reg;
  logic [N_AN-1:0]       an_reg;
  logic [3:0]            digit_reg;
  logic                  dp_n_reg;
  logic                  win_ack_reg;
  logic                  frame_tick_reg;

  logic                  p_wrap;
  logic                  boundary;
  logic [OFS_W-1:0]      req_ofs;
  logic [3:0]            win_dig [N_AN];
  logic [N_AN-1:0]       win_dp;
  logic [N_AN-1:0]       blank;
  logic                  slot_blank;
  logic [N_AN-1:0]       an_next;

  assign p_wrap   = (p_reg == '1);
  assign boundary = p_wrap && (s_reg == S_LAST);
  assign req_ofs  = (win_sel > MAX_OFS) ? MAX_OFS : win_sel;

  // Window view: slot gi shows input digit offset+gi.
  genvar gi;
  generate
    for (gi = 0; gi < N_AN; gi++) begin : g_win
      logic [IDX_W-1:0] idx;
      assign idx         = IDX_W'(offset_reg) + IDX_W'(gi);
      assign win_dig[gi] = digits_in[4*idx +: 4];
      assign win_dp[gi]  = dp_in[idx];
    end
  endgenerate

`ifdef SEVENSEG_LZB_EN
  logic zero_run;
  // A slot is dark when it and every higher slot in the window hold zero; slot 0 always shows.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = N_AN - 1; k >= 0; k--) begin
      zero_run = zero_run && (win_dig[k] == 4'd0);
      if (k != 0) blank[k] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  assign slot_blank = blank[s_reg];

  always_comb begin
    an_next = '1;
    if (p_reg >= GUARD_P && !slot_blank) an_next[s_reg] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg             <= '0;
      s_reg             <= '0;
      offset_reg        <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
      an_reg            <= '1;
      digit_reg         <= 4'd0;
      dp_n_reg          <= 1'b1;
      win_ack_reg       <= 1'b0;
      frame_tick_reg    <= 1'b0;
    end else begin
      p_reg <= p_reg + 1'b1;
      if (p_wrap) s_reg <= (s_reg == S_LAST) ? '0 : s_reg + 1'b1;

      if (boundary && pending_valid_reg) offset_reg <= pending_reg;
      // A request in the boundary cycle itself survives into the next frame.
      if (win_req) begin
        pending_reg       <= req_ofs;
        pending_valid_reg <= 1'b1;
      end else if (boundary) begin
        pending_valid_reg <= 1'b0;
      end

      an_reg         <= an_next;
      digit_reg      <= win_dig[s_reg];
      dp_n_reg       <= ~(win_dp[s_reg] && !slot_blank);
      frame_tick_reg <= boundary;
      win_ack_reg    <= boundary && pending_valid_reg;
    end
  end

  assign an         = an_reg;
  assign digit_out  = digit_reg;
  assign dp_n       = dp_n_reg;
  assign win_ack    = win_ack_reg;
  assign frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Bench for seven_seg_scan_mux: cycle-count based reference model plus literal scan/window checks.
module tb_seven_seg_scan_mux;
  localparam int N_AN = 4, N_DIG = 6, GUARD = 1, DWELL = 4, FRAME = 16, MAXOFS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] digits_in;
  logic [5:0]  dp_in;
  logic [1:0]  win_sel;
  logic        win_req;
  logic        win_ack;
  logic [3:0]  an;
  logic [3:0]  digit_out;
  logic        dp_n;
  logic        frame_tick;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  seven_seg_scan_mux #(
    .N_AN(N_AN), .N_DIG(N_DIG), .PRESCALE_W(2), .GUARD(GUARD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .win_sel(win_sel), .win_req(win_req), .win_ack(win_ack), .an(an),
    .digit_out(digit_out), .dp_n(dp_n), .frame_tick(frame_tick)
  );

  // Reference model: position in the scan is derived from a plain cycle count.
  int   cyc, m_off, m_pend;
  bit   m_pv;
  logic [3:0] e_an, e_dig;
  logic e_dp_n, e_ack, e_tick;

  function automatic int slot_of(int c);
    return (c / DWELL) % N_AN;
  endfunction

  function automatic bit dark_f(int s, int off, logic [23:0] dg);
`ifdef SEVENSEG_LZB_EN
    if (s == 0) return 1'b0;
    for (int k = s; k < N_AN; k++) if (dg[4*(off+k) +: 4] != 4'd0) return 1'b0;
    return 1'b1;
`else
    return (s < 0) && (off < 0) && (dg == 24'hx);
`endif
  endfunction

  function automatic logic [3:0] exp_an(int c, int off, logic [23:0] dg);
    if ((c % DWELL) >= GUARD && !dark_f(slot_of(c), off, dg)) return ~(4'b0001 << slot_of(c));
    return 4'hF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; m_off <= 0; m_pend <= 0; m_pv <= 1'b0;
      e_an <= 4'hF; e_dig <= 4'd0; e_dp_n <= 1'b1; e_ack <= 1'b0; e_tick <= 1'b0;
    end else begin
      e_an   <= exp_an(cyc, m_off, digits_in);
      e_dig  <= digits_in[4*(m_off + slot_of(cyc)) +: 4];
      e_dp_n <= ~(dp_in[m_off + slot_of(cyc)] && !dark_f(slot_of(cyc), m_off, digits_in));
      e_tick <= (cyc % FRAME) == FRAME - 1;
      e_ack  <= ((cyc % FRAME) == FRAME - 1) && m_pv;
      if (((cyc % FRAME) == FRAME - 1) && m_pv) m_off <= m_pend;
      if (win_req) begin
        m_pend <= (int'(win_sel) > MAXOFS) ? MAXOFS : int'(win_sel);
        m_pv   <= 1'b1;
      end else if ((cyc % FRAME) == FRAME - 1) begin
        m_pv <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      chk("an", 32'(an), 32'(e_an));
      chk("digit_out", 32'(digit_out), 32'(e_dig));
      chk("dp_n", 32'(dp_n), 32'(e_dp_n));
      chk("win_ack", 32'(win_ack), 32'(e_ack));
      chk("frame_tick", 32'(frame_tick), 32'(e_tick));
    end
  endtask

  task automatic wait_ack(input int lim);
    bit got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      tick();
      if (win_ack === 1'b1) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ack_timeout: got none want win_ack within %0d cycles", lim);
    end
  endtask

  task automatic wait_tick(input int lim);
    bit got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      tick();
      if (frame_tick === 1'b1) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL tick_timeout: got none want frame_tick within %0d cycles", lim);
    end
  endtask

  task automatic pulse_req(input logic [1:0] sel);
    win_sel = sel; win_req = 1'b1;
    tick();
    win_req = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_digit"}, 32'(digit_out), 32'h0);
    chk({tag, "_dp_n"}, 32'(dp_n), 32'h1);
    chk({tag, "_ack"}, 32'(win_ack), 32'h0);
    chk({tag, "_tick"}, 32'(frame_tick), 32'h0);
  endtask

  logic [3:0] an_tab  [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
  logic [3:0] lzb_tab [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                               4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

  initial begin
    int acks;
    digits_in = 24'h654321; dp_in = 6'b000101; win_sel = 2'd0; win_req = 1'b0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    chk_en = 1;
    tick();
    rst_n = 1'b1;

    // First frame after release: guard cycle then three lit cycles per slot.
    for (int i = 0; i < FRAME; i++) begin
      tick();
      chk("an_seq", 32'(an), 32'(an_tab[i]));
      chk("dig_seq", 32'(digit_out), 32'(i / DWELL + 1));
      chk("tick_pos", 32'(frame_tick), 32'(i == FRAME - 1));
    end

    // Mid-frame request for offset 2.
    repeat (3) tick();
    pulse_req(2'd2);
    wait_ack(40);
    chk("ack_with_tick", 32'(frame_tick), 32'h1);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      chk("win2_digit", 32'(digit_out), 32'(i / DWELL + 3));
    end

    // Over-range offset clamps to 2.
    repeat (3) tick();
    pulse_req(2'd3);
    wait_ack(40);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      chk("clamp_digit", 32'(digit_out), 32'(i / DWELL + 3));
    end

    // Two requests in one frame: latest wins, one ack.
    repeat (2) tick();
    pulse_req(2'd1);
    tick();
    pulse_req(2'd0);
    wait_ack(40);
    acks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (i < FRAME) chk("latest_digit", 32'(digit_out), 32'(i / DWELL + 1));
      if (win_ack === 1'b1) acks++;
    end
    chk("single_ack", 32'(acks), 32'h0);

    // Request landing exactly in the boundary cycle.
    wait_tick(40);
    repeat (15) tick();
    win_sel = 2'd1; win_req = 1'b1;
    tick();
    win_req = 1'b0;
    chk("bnd_tick", 32'(frame_tick), 32'h1);
    chk("bnd_no_ack", 32'(win_ack), 32'h0);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      chk("bnd_late_ack", 32'(win_ack), 32'(i == FRAME - 1));
    end

    // Asynchronous reset mid-dwell with a request pending.
    repeat (5) tick();
    pulse_req(2'd2);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    tick();
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (win_ack === 1'b1) acks++;
    end
    chk("no_ack_after_rst", 32'(acks), 32'h0);

    // Leading zeros with offset 0.
    digits_in = 24'h000050;
    wait_tick(40);
    for (int i = 0; i < FRAME; i++) begin
      tick();
`ifdef SEVENSEG_LZB_EN
      chk("lzb_an", 32'(an), 32'(lzb_tab[i]));
`else
      chk("nolzb_an", 32'(an), 32'(an_tab[i]));
`endif
      if (i / DWELL == 1) chk("lzb_dig5", 32'(digit_out), 32'h5);
      if (i / DWELL == 0) chk("lzb_dig0", 32'(digit_out), 32'h0);
    end
    digits_in = 24'h000000;
    wait_tick(40);
    for (int i = 0; i < FRAME; i++) begin
      tick();
`ifdef SEVENSEG_LZB_EN
      chk("allzero_an", 32'(an), 32'((i < DWELL && i % DWELL != 0) ? 4'hE : 4'hF));
`else
      chk("allzero_an", 32'(an), 32'(an_tab[i]));
`endif
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int k = 0; k < N_DIG; k++)
        digits_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      dp_in   = 6'($urandom);
      win_sel = 2'($urandom);
      win_req = ($urandom_range(0, 19) == 0);
    end
    win_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
